seg7_scan_controller: RTL and testbench
=======================================

Name: seg7_scan_controller

Overview:
- Parametrised successor to the fixed 8-digit display path.
- Scans NUM_DIGITS hex digits onto a common 7-segment bank with:
  - a built-in refresh divider,
  - tear-free double-buffered data loading,
  - 16-level PWM brightness,
  - optional leading-zero blanking.
- Sits between the register-file/datapath outputs and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 8: digits scanned, 2..16.
- TICK_DIV, 1000: clk cycles per PWM tick, ≥2.
- DIGIT_W, 4: bits per digit (fixed at 4; exposed for width math, DATA_W = NUM_DIGITS*DIGIT_W).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- data_in, input, NUM_DIGITS*4: digit nibbles; digit i = data_in[4i+3:4i]; digit NUM_DIGITS-1 is leftmost.
- load, input, 1: one-cycle strobe; captures data_in into pending buffer.
- brightness, input, 4: PWM level 0..15; sampled live.
- blank_lz, input, 1: 1 enables leading-zero blanking; sampled live.
- anode, output, NUM_DIGITS: active-low digit enables, registered.
- seg, output, 7: active-low segments {A,B,C,D,E,F,G}, A at bit 6, registered.
- frame_start, output, 1: one-cycle pulse when scan returns to digit 0.
- upd_done, output, 1: one-cycle pulse when the pending buffer is committed to the active buffer.

Behaviour:
- Reset (async, immediate):
  - anode all 1s and seg 7'h7F.
  - tick counter, phase, and digit index all 0.
  - active and pending buffers 0; pending_valid 0.
  - frame_start and upd_done 0.
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick = 1 in the cycle the counter equals TICK_DIV-1.
- Phase: 4-bit, increments on tick, wraps 15→0.
- Digit index: increments on tick when phase == 15; wraps NUM_DIGITS-1 → 0. Each digit therefore occupies 16*TICK_DIV cycles.
- Frame boundary: the cycle where tick && phase==15 && index==NUM_DIGITS-1.
  - frame_start pulses the following cycle, aligned with index==0.
- Load handshake:
  - load=1 copies data_in to pending and sets pending_valid.
  - A second load before commit overwrites pending (last wins); no error.
- Commit: at a frame boundary with pending_valid=1:
  - active ← pending and pending_valid ← 0.
  - upd_done pulses the next cycle, coincident with frame_start.
  - Load in the same cycle as a commit: the commit uses the pre-edge pending value; the new data lands in pending and pending_valid stays 1 for the next frame.
- Leading-zero blanking: digit i is blanked when blank_lz=1, i≠0, and all active nibbles from NUM_DIGITS-1 down to i are 0. Digit 0 is never blanked.
- Output enable: lit = !blanked && (phase < brightness).
  - brightness=0 keeps all anodes high.
  - brightness=15 gives 15/16 duty.
- Output registers (one-cycle latency from internal state):
  - When lit: anode = ~(1<<index) and seg = hex pattern of the active nibble.
  - When not lit: anode all 1s and seg 7'h7F.
  - Never more than one anode low.
- Hex patterns (active-low, ABCDEFG):
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38
- Reset mid-frame: scan restarts at digit 0, phase 0; any uncommitted pending data is lost.

Optional Feature:
- Macro: SEG7_DP_EN.
- Defined:
  - Adds input dp_in [NUM_DIGITS-1:0], captured into pending/active alongside data_in.
  - Adds output dp (active-low, registered, same timing as seg): dp=0 when the lit digit's dp bit is 1, else 1. Reset value 1.
  - A digit whose dp bit is 1 is not a leading zero: it stops blanking for itself and all lower digits.
- Undefined: no dp_in/dp ports; blanking is as described above.

Test Plan:
- Bench parameters: NUM_DIGITS=8, TICK_DIV=4.
- Reset then release, brightness=15, load data_in=32'h1234_ABCD → after first frame_start, upd_done pulses once; digit 7 window shows anode=8'h7F, seg=7'h4F; digit 0 window shows anode=8'hFE, seg=7'h42; digit slot length 64 cycles.
- brightness=4 → within each 64-cycle slot, anode low for exactly 16 cycles (phases 0..3); brightness=0 → anode stays 8'hFF all frame.
- blank_lz=1, data 32'h0000_0070 → digits 7..2 anode high all frame; digit 1 shows seg=7'h0F, digit 0 shows 7'h01; with blank_lz=0, digit 7 shows 7'h01.
- Two loads (32'h1111_1111, then 32'h2222_2222) mid-frame → commit at the next boundary shows 2s only; load asserted exactly in the boundary cycle → that value appears one frame later, upd_done pulses again.
- Assert reset mid-digit-3 → anode=8'hFF and seg=7'h7F immediately (same cycle, async); after release, scan resumes at digit 0 and active data reads 0.
- SEG7_DP_EN defined, blank_lz=1, data 32'h0, dp_in=8'h04 → digits 2..0 lit, dp=0 only during digit 2, digits 7..3 blanked.

Source files
------------

// File: rtl/seg7_scan_controller.sv
// Multiplexed hex display driver for a common 7-segment bank.
// It scans NUM_DIGITS digits through a refresh divider and dims them with 16-level PWM.
// New data is double-buffered and committed only at a frame boundary, so a frame never tears.
// Leading-zero blanking is optional.
// Define SEG7_DP_EN to add per-digit decimal points through the dp_in and dp ports.
module seg7_scan_controller #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned DIGIT_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] data_in,
    input  logic                          load,
    input  logic [3:0]                    brightness,
    input  logic                          blank_lz,
`ifdef SEG7_DP_EN
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic                          dp,
`endif
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [6:0]                    seg,
    output logic                          frame_start,
    output logic                          upd_done
);

    localparam int unsigned DATA_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CNT_W  = $clog2(TICK_DIV);
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]      tick_cnt;
    logic [3:0]            phase;
    logic [IDX_W-1:0]      idx;
    logic [DATA_W-1:0]     active;
    logic [DATA_W-1:0]     pending;
    logic                  pending_valid;
    logic                  tick;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] blanked;
    logic [NUM_DIGITS-1:0] dp_active;
    logic [DIGIT_W-1:0]    cur_nib;
    logic                  cur_blank;
    logic                  lit;

    assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign boundary = tick && (phase == 4'd15) && (idx == IDX_W'(NUM_DIGITS - 1));
    assign lit      = !cur_blank && (phase < brightness);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'h01;
            4'h1:    hex_to_seg = 7'h4F;
            4'h2:    hex_to_seg = 7'h12;
            4'h3:    hex_to_seg = 7'h06;
            4'h4:    hex_to_seg = 7'h4C;
            4'h5:    hex_to_seg = 7'h24;
            4'h6:    hex_to_seg = 7'h20;
            4'h7:    hex_to_seg = 7'h0F;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h04;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h60;
            4'hC:    hex_to_seg = 7'h31;
            4'hD:    hex_to_seg = 7'h42;
            4'hE:    hex_to_seg = 7'h30;
            default: hex_to_seg = 7'h38;
        endcase
    endfunction

    // Refresh divider, PWM phase and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            phase    <= '0;
            idx      <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                phase <= phase + 4'd1;
                if (phase == 4'd15) begin
                    idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    // Double buffer: a load in the commit cycle stays pending for the following frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (boundary && pending_valid) begin
                active <= pending;
            end
            if (load) begin
                pending       <= data_in;
                pending_valid <= 1'b1;
            end else if (boundary) begin
                pending_valid <= 1'b0;
            end
        end
    end

`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0] dp_pending;
    logic                  cur_dp;

    // Decimal points travel through the same double buffer as the nibbles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_active  <= '0;
            dp_pending <= '0;
        end else begin
            if (boundary && pending_valid) begin
                dp_active <= dp_pending;
            end
            if (load) begin
                dp_pending <= dp_in;
            end
        end
    end

    // Select the decimal point of the digit being scanned
    always_comb begin
        cur_dp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_dp = dp_active[i];
            end
        end
    end

    // Registered decimal point, same timing as seg
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp <= 1'b1;
        end else begin
            dp <= !(lit && cur_dp);
        end
    end
`else
    assign dp_active = '0;
`endif

    // Blank a digit while every digit from the leftmost down to it is zero with no point lit
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blanked  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (active[i*DIGIT_W +: DIGIT_W] == '0) && !dp_active[i];
            blanked[i] = blank_lz && zero_run;
        end
    end

    // Select the nibble and blanking state of the digit being scanned
    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = active[i*DIGIT_W +: DIGIT_W];
                cur_blank = blanked[i];
            end
        end
    end

    // Registered pin drivers and event pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode       <= '1;
            seg         <= 7'h7F;
            frame_start <= 1'b0;
            upd_done    <= 1'b0;
        end else begin
            anode       <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg         <= lit ? hex_to_seg(cur_nib) : 7'h7F;
            frame_start <= boundary;
            upd_done    <= boundary && pending_valid;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench for seg7_scan_controller with NUM_DIGITS=8 and TICK_DIV=4.
// A behavioural model pushes the expected pin state to a queue on every clock.
// Every test task pops that queue each cycle and also makes its own scenario checks.
module tb_seg7_scan_controller;

    localparam int ND = 8;
    localparam int TD = 4;

    typedef struct packed {
        logic [7:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
        logic       ud;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_in = '0;
    logic        load = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic        blank_lz = 1'b0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        frame_start;
    logic        upd_done;
    logic        dp_w;

    int n_cmp = 0;
    int n_fail = 0;

    exp_t sb[$];

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD),
        .DIGIT_W    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .load        (load),
        .brightness  (brightness),
        .blank_lz    (blank_lz),
`ifdef SEG7_DP_EN
        .dp_in       (dp_in),
        .dp          (dp_w),
`endif
        .anode       (anode),
        .seg         (seg),
        .frame_start (frame_start),
        .upd_done    (upd_done)
    );

`ifndef SEG7_DP_EN
    assign dp_w = 1'b1;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        return t[n];
    endfunction

    function automatic exp_t model_out(input logic [31:0] act, input logic [7:0] dpv,
                                       input logic [3:0] ph, input int di, input logic [3:0] br,
                                       input logic blz, input logic bnd, input logic pv);
        exp_t e;
        logic blank;
        e.anode = 8'hFF;
        e.seg   = 7'h7F;
        e.dp    = 1'b1;
        e.fs    = bnd;
        e.ud    = bnd && pv;
        blank = blz && (di != 0) && ((act >> (4 * di)) == 32'd0) && ((dpv >> di) == 8'd0);
        if (!blank && (ph < br)) begin
            e.anode = ~(8'd1 << di);
            e.seg   = hex7(act[4*di +: 4]);
            e.dp    = ~dpv[di];
        end
        return e;
    endfunction

    // Reference model of the scan and double buffer; one expected entry per clock
    int          m_cnt;
    int          m_idx;
    logic [3:0]  m_phase;
    logic [31:0] m_act, m_pend;
    logic [7:0]  m_dact, m_dpend;
    logic        m_pv;
    logic        m_bnd;
    assign m_bnd = (m_cnt == TD - 1) && (m_phase == 4'd15) && (m_idx == ND - 1);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt   <= 0;
            m_idx   <= 0;
            m_phase <= '0;
            m_act   <= '0;
            m_pend  <= '0;
            m_dact  <= '0;
            m_dpend <= '0;
            m_pv    <= 1'b0;
            sb.delete();
        end else begin
            sb.push_back(model_out(m_act, m_dact, m_phase, m_idx, brightness, blank_lz,
                                   m_bnd, m_pv));
            if (m_bnd && m_pv) begin
                m_act  <= m_pend;
                m_dact <= m_dpend;
            end
            if (load) begin
                m_pend  <= data_in;
                m_dpend <= dp_in;
                m_pv    <= 1'b1;
            end else if (m_bnd) begin
                m_pv <= 1'b0;
            end
            if (m_cnt == TD - 1) begin
                m_cnt   <= 0;
                m_phase <= m_phase + 4'd1;
                if (m_phase == 4'd15) m_idx <= (m_idx == ND - 1) ? 0 : m_idx + 1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Pops one expected entry and compares all pins against it; used once per negedge
`define SB_CHECK(tag) \
    n_cmp++; \
    if (sb.size() == 0) begin \
        n_fail++; \
        $display("FAIL sb_%s: expected entry missing at %0t", tag, $time); \
    end else begin \
        if ({anode, seg, dp_w, frame_start, upd_done} !== sb[0]) begin \
            n_fail++; \
            $display("FAIL sb_%s @%0t: got an=%h seg=%h dp=%b fs=%b ud=%b want an=%h seg=%h dp=%b fs=%b ud=%b", \
                     tag, $time, anode, seg, dp_w, frame_start, upd_done, \
                     sb[0].anode, sb[0].seg, sb[0].dp, sb[0].fs, sb[0].ud); \
        end \
        sb.delete(0); \
    end

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (anode !== 8'hFF) begin n_fail++; $display("FAIL rst_anode: got %h want ff", anode); end
        n_cmp++;
        if (seg !== 7'h7F) begin n_fail++; $display("FAIL rst_seg: got %h want 7f", seg); end
        n_cmp++;
        if ({frame_start, upd_done} !== 2'b00) begin
            n_fail++; $display("FAIL rst_pulses: got %b want 00", {frame_start, upd_done});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({anode, seg, dp_w} !== {8'hFF, 7'h7F, 1'b1}) begin
            n_fail++; $display("FAIL rst_held: got %h/%h/%b want ff/7f/1", anode, seg, dp_w);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_commit();
        int c7 = 0, c0 = 0, ud = 0, fs = 0;
        logic got = 1'b0;
        brightness = 4'd15;
        data_in = 32'h1234_ABCD;
        load = 1'b1;
        @(negedge clk); `SB_CHECK("lc_load")
        load = 1'b0;
        for (int k = 0; k < 1100 && !got; k++) begin
            @(negedge clk); `SB_CHECK("lc_wait")
            got = frame_start;
        end
        n_cmp++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL lc_wait_fs: got %b want 1", got); end
        ud += int'(upd_done);
        fs += int'(frame_start);
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk); `SB_CHECK("lc_frame")
            if (anode == 8'h7F && seg == 7'h4F) c7++;
            if (anode == 8'hFE && seg == 7'h42) c0++;
            ud += int'(upd_done);
            if (frame_start) fs += (i == 512) ? 1 : 100;
        end
        n_cmp++;
        if (c7 !== 60) begin n_fail++; $display("FAIL lc_digit7: got %0d cycles want 60", c7); end
        n_cmp++;
        if (c0 !== 60) begin n_fail++; $display("FAIL lc_digit0: got %0d cycles want 60", c0); end
        n_cmp++;
        if (ud !== 1) begin n_fail++; $display("FAIL lc_upd_once: got %0d pulses want 1", ud); end
        n_cmp++;
        if (fs !== 2) begin n_fail++; $display("FAIL lc_frame_len: got code %0d want 2", fs); end
    endtask

    task automatic test_brightness();
        int fe = 0, low = 0, low0 = 0;
        logic got = 1'b0;
        for (int k = 0; k < 1100 && !got; k++) begin
            @(negedge clk); `SB_CHECK("br_wait")
            got = frame_start;
        end
        n_cmp++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL br_wait_fs: got %b want 1", got); end
        brightness = 4'd4;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk); `SB_CHECK("br_4")
            if (anode == 8'hFE) fe++;
            if (anode != 8'hFF) low++;
        end
        brightness = 4'd0;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk); `SB_CHECK("br_0")
            if (anode != 8'hFF) low0++;
        end
        n_cmp++;
        if (fe !== 16) begin n_fail++; $display("FAIL br4_slot: got %0d cycles want 16", fe); end
        n_cmp++;
        if (low !== 128) begin n_fail++; $display("FAIL br4_frame: got %0d cycles want 128", low); end
        n_cmp++;
        if (low0 !== 0) begin n_fail++; $display("FAIL br0_dark: got %0d cycles want 0", low0); end
    endtask

    task automatic test_blanking();
        int d1 = 0, d0 = 0, hi = 0, c7 = 0;
        logic got = 1'b0;
        blank_lz = 1'b1;
        data_in = 32'h0000_0070;
        load = 1'b1;
        @(negedge clk); `SB_CHECK("bl_load")
        load = 1'b0;
        for (int k = 0; k < 1100 && !got; k++) begin
            @(negedge clk); `SB_CHECK("bl_wait")
            got = upd_done;
        end
        n_cmp++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL bl_wait_upd: got %b want 1", got); end
        brightness = 4'd15;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk); `SB_CHECK("bl_on")
            if (anode == 8'hFD && seg == 7'h0F) d1++;
            if (anode == 8'hFE && seg == 7'h01) d0++;
            if (anode[7:2] != 6'h3F) hi++;
        end
        blank_lz = 1'b0;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk); `SB_CHECK("bl_off")
            if (anode == 8'h7F && seg == 7'h01) c7++;
        end
        n_cmp++;
        if (d1 !== 60) begin n_fail++; $display("FAIL bl_digit1: got %0d cycles want 60", d1); end
        n_cmp++;
        if (d0 !== 60) begin n_fail++; $display("FAIL bl_digit0: got %0d cycles want 60", d0); end
        n_cmp++;
        if (hi !== 0) begin n_fail++; $display("FAIL bl_upper_lit: got %0d cycles want 0", hi); end
        n_cmp++;
        if (c7 !== 60) begin n_fail++; $display("FAIL bl_off_digit7: got %0d cycles want 60", c7); end
    endtask

    task automatic test_back_to_back();
        int ones = 0, twos = 0, fours = 0, threes = 0;
        logic got = 1'b0;
        data_in = 32'h1111_1111;
        load = 1'b1;
        @(negedge clk); `SB_CHECK("bb_l1")
        load = 1'b0;
        repeat (3) begin @(negedge clk); `SB_CHECK("bb_gap") end
        data_in = 32'h2222_2222;
        load = 1'b1;
        @(negedge clk); `SB_CHECK("bb_l2")
        load = 1'b0;
        for (int k = 0; k < 1100 && !got; k++) begin
            @(negedge clk); `SB_CHECK("bb_wait")
            got = upd_done;
        end
        n_cmp++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL bb_wait_upd: got %b want 1", got); end
        for (int i = 1; i <= 1536; i++) begin
            @(negedge clk); `SB_CHECK("bb_run")
            load = 1'b0;
            if (i <= 512) begin
                if (seg == 7'h4F) ones++;
                if (seg == 7'h12) twos++;
            end else if (i <= 1024) begin
                if (seg == 7'h4C) fours++;
            end else if (seg == 7'h06) begin
                threes++;
            end
            if (i == 512 || i == 1024) begin
                n_cmp++;
                if (upd_done !== 1'b1) begin
                    n_fail++; $display("FAIL bb_upd_%0d: got %b want 1", i, upd_done);
                end
            end
            if (i == 100) begin data_in = 32'h4444_4444; load = 1'b1; end
            // Lands in the very cycle that commits the 4s
            if (i == 511) begin data_in = 32'h3333_3333; load = 1'b1; end
        end
        n_cmp++;
        if (ones !== 0) begin n_fail++; $display("FAIL bb_overwritten: got %0d want 0", ones); end
        n_cmp++;
        if (twos !== 480) begin n_fail++; $display("FAIL bb_last_wins: got %0d want 480", twos); end
        n_cmp++;
        if (fours !== 480) begin n_fail++; $display("FAIL bb_commit: got %0d want 480", fours); end
        n_cmp++;
        if (threes !== 480) begin n_fail++; $display("FAIL bb_deferred: got %0d want 480", threes); end
    endtask

    task automatic test_reset_mid();
        int zeros = 0, fives = 0, ud = 0;
        logic got = 1'b0;
        for (int k = 0; k < 1100 && !got; k++) begin
            @(negedge clk); `SB_CHECK("rm_wait")
            got = frame_start;
        end
        n_cmp++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL rm_wait_fs: got %b want 1", got); end
        for (int i = 1; i <= 3 * 64 + 10; i++) begin
            @(negedge clk); `SB_CHECK("rm_pre")
            load = 1'b0;
            if (i == 5) begin data_in = 32'h5555_5555; load = 1'b1; end
        end
        n_cmp++;
        if ({anode, seg} !== {8'hF7, 7'h06}) begin
            n_fail++; $display("FAIL rm_digit3: got %h/%h want f7/06", anode, seg);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({anode, seg} !== {8'hFF, 7'h7F}) begin
            n_fail++; $display("FAIL rm_async: got %h/%h want ff/7f", anode, seg);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 1024; i++) begin
            @(negedge clk); `SB_CHECK("rm_post")
            if (i == 1) begin
                n_cmp++;
                if ({anode, seg} !== {8'hFE, 7'h01}) begin
                    n_fail++; $display("FAIL rm_restart: got %h/%h want fe/01", anode, seg);
                end
            end
            if (seg == 7'h01) zeros++;
            if (seg == 7'h24) fives++;
            ud += int'(upd_done);
        end
        n_cmp++;
        if (zeros !== 960) begin n_fail++; $display("FAIL rm_cleared: got %0d want 960", zeros); end
        n_cmp++;
        if (fives !== 0) begin n_fail++; $display("FAIL rm_pend_lost: got %0d want 0", fives); end
        n_cmp++;
        if (ud !== 0) begin n_fail++; $display("FAIL rm_no_upd: got %0d want 0", ud); end
    endtask

`ifdef SEG7_DP_EN
    task automatic test_dp();
        int hi = 0, c2 = 0, dpl = 0, c1 = 0, c0 = 0;
        logic got = 1'b0;
        blank_lz = 1'b1;
        brightness = 4'd15;
        data_in = 32'h0;
        dp_in = 8'h04;
        load = 1'b1;
        @(negedge clk); `SB_CHECK("dp_load")
        load = 1'b0;
        for (int k = 0; k < 1100 && !got; k++) begin
            @(negedge clk); `SB_CHECK("dp_wait")
            got = upd_done;
        end
        n_cmp++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL dp_wait_upd: got %b want 1", got); end
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk); `SB_CHECK("dp_run")
            if (anode[7:3] != 5'h1F) hi++;
            if (anode == 8'hFB && seg == 7'h01 && dp_w == 1'b0) c2++;
            if (dp_w == 1'b0) dpl++;
            if (anode == 8'hFD && dp_w == 1'b1) c1++;
            if (anode == 8'hFE && dp_w == 1'b1) c0++;
        end
        n_cmp++;
        if (hi !== 0) begin n_fail++; $display("FAIL dp_upper_lit: got %0d want 0", hi); end
        n_cmp++;
        if (c2 !== 60) begin n_fail++; $display("FAIL dp_digit2: got %0d want 60", c2); end
        n_cmp++;
        if (dpl !== 60) begin n_fail++; $display("FAIL dp_only2: got %0d want 60", dpl); end
        n_cmp++;
        if (c1 !== 60 || c0 !== 60) begin
            n_fail++; $display("FAIL dp_lower: got %0d/%0d want 60/60", c1, c0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_commit();
        test_brightness();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
`ifdef SEG7_DP_EN
        test_dp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
